sm83_cpu_core: RTL and testbench

- Minimal SM83 (Game Boy) CPU core: fetches and executes a subset of the instruction set, enough to run the boot-ROM VRAM-clear loop.
- Talks to an external synchronous ROM (1-clock read latency) and work RAM over a shared 16-bit address bus and a tri-state 8-bit data bus.
- Sits at the top of the CPU hierarchy, below the system top that instantiates the boot ROM and work RAM.

---
 rtl/sm83_pkg.sv | 28 ++
 rtl/sm83_alu.sv | 31 +++
 rtl/sm83_cpu_core.sv | 168 ++++++++++++++++
 tb/tb_sm83_cpu_core.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared types and constants for the minimal SM83 core: FSM states, opcodes, flag positions.
package sm83_pkg;

  typedef enum logic [3:0] {
    FETCH_A, FETCH_D, DECODE, OPR1_A, OPR1_D, OPR2_A, OPR2_D, EXEC, WRITE, HALT
  } state_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LD_SP  = 8'h31;
  localparam logic [7:0] OP_LD_HL  = 8'h21;
  localparam logic [7:0] OP_LD_A   = 8'h3E;
  localparam logic [7:0] OP_XOR_A  = 8'hAF;
  localparam logic [7:0] OP_LDD    = 8'h32;
  localparam logic [7:0] OP_LDI    = 8'h22;
  localparam logic [7:0] OP_JP     = 8'hC3;
  localparam logic [7:0] OP_JR     = 8'h18;
  localparam logic [7:0] OP_JR_NZ  = 8'h20;
  localparam logic [7:0] OP_JR_Z   = 8'h28;
  localparam logic [7:0] OP_CB     = 8'hCB;
  localparam logic [7:0] OP_HALT   = 8'h76;
  localparam logic [7:0] CB_BIT7H  = 8'h7C;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

endpackage

// File: rtl/sm83_alu.sv
// Combinational helpers: XOR A, BIT 7,H flag generation and PC-relative jump target.
module sm83_alu
  import sm83_pkg::*;
(
  input  logic [7:0]  a,
  input  logic        c,
  input  logic        h_msb,
  input  logic [15:0] pc,
  input  logic [7:0]  e8,
  output logic [7:0]  xor_result,
  output logic [7:0]  xor_flags,
  output logic [7:0]  bit_flags,
  output logic [15:0] pc_rel
);

  always_comb begin
    xor_result = a ^ a;
    xor_flags = 8'h00;
    xor_flags[FLAG_Z] = (xor_result == 8'h00);

    // BIT leaves carry untouched and always sets half-carry
    bit_flags = 8'h00;
    bit_flags[FLAG_Z] = ~h_msb;
    bit_flags[FLAG_N] = 1'b0;
    bit_flags[FLAG_H] = 1'b1;
    bit_flags[FLAG_C] = c;

    pc_rel = pc + {{8{e8[7]}}, e8};
  end

endmodule

// File: rtl/sm83_cpu_core.sv
// Minimal SM83 core: multi-cycle fetch/decode/execute over a shared address/data bus.
module sm83_cpu_core
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_oe,
  output logic        mem_cs,
  output logic        mem_wr,
  inout  wire  [7:0]  data_bus_ext,
  output logic [15:0] addr_bus_ext,
  output logic [15:0] dbg_pc,
  output logic [15:0] dbg_af,
  output logic [15:0] dbg_hl,
  output logic [15:0] dbg_sp,
  output logic        halted
);

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, sp_reg;
  logic [7:0]  a_reg, f_reg, h_reg, l_reg, op_reg, lo_reg;
  logic [7:0]  alu_xor_result, alu_xor_flags, alu_bit_flags;
  logic [15:0] alu_pc_rel;
  logic        jr_taken;

  sm83_alu u_alu (
    .a          (a_reg),
    .c          (f_reg[FLAG_C]),
    .h_msb      (h_reg[7]),
    .pc         (pc_reg),
    .e8         (lo_reg),
    .xor_result (alu_xor_result),
    .xor_flags  (alu_xor_flags),
    .bit_flags  (alu_bit_flags),
    .pc_rel     (alu_pc_rel)
  );

  assign jr_taken = (op_reg == OP_JR) ||
                    (op_reg == OP_JR_NZ && !f_reg[FLAG_Z]) ||
                    (op_reg == OP_JR_Z  &&  f_reg[FLAG_Z]);

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= FETCH_A;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH_A;
    case (state_reg)
      FETCH_A: state_next = FETCH_D;
      FETCH_D: state_next = DECODE;
      DECODE: begin
        case (op_reg)
          OP_LD_SP, OP_LD_HL, OP_JP, OP_LD_A,
          OP_JR, OP_JR_NZ, OP_JR_Z, OP_CB: state_next = OPR1_A;
          OP_LDD, OP_LDI:                  state_next = WRITE;
          OP_HALT:                         state_next = HALT;
          default:                         state_next = FETCH_A;
        endcase
      end
      OPR1_A: state_next = OPR1_D;
      OPR1_D: begin
        // 8-bit loads finish here; 16-bit loads fetch a second byte; JR/CB need EXEC
        if (op_reg == OP_LD_SP || op_reg == OP_LD_HL || op_reg == OP_JP) state_next = OPR2_A;
        else if (op_reg == OP_LD_A)                                        state_next = FETCH_A;
        else                                                               state_next = EXEC;
      end
      OPR2_A:  state_next = OPR2_D;
      OPR2_D:  state_next = FETCH_A;
      EXEC:    state_next = FETCH_A;
      WRITE:   state_next = FETCH_A;
      HALT:    state_next = HALT;
      default: state_next = FETCH_A;
    endcase
  end

  // Bus strobes are suppressed combinationally while reset is held so an aborted write never lands
  always_comb begin
    mem_oe       = 1'b0;
    mem_cs       = 1'b0;
    mem_wr       = 1'b0;
    addr_bus_ext = 16'h0000;
    halted       = 1'b0;
    if (rst) begin
      case (state_reg)
        FETCH_A, FETCH_D, OPR1_A, OPR1_D, OPR2_A, OPR2_D: begin
          mem_cs       = 1'b1;
          mem_oe       = 1'b1;
          addr_bus_ext = pc_reg;
        end
        WRITE: begin
          mem_cs       = 1'b1;
          mem_wr       = 1'b1;
          addr_bus_ext = {h_reg, l_reg};
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign data_bus_ext = mem_wr ? a_reg : 8'hzz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
      sp_reg <= RESET_SP;
      a_reg  <= 8'h00;
      f_reg  <= 8'h00;
      h_reg  <= 8'h00;
      l_reg  <= 8'h00;
      op_reg <= 8'h00;
      lo_reg <= 8'h00;
    end else begin
      case (state_reg)
        FETCH_D: begin
          op_reg <= data_bus_ext;
          pc_reg <= pc_reg + 16'd1;
        end
        DECODE: begin
          if (op_reg == OP_XOR_A) begin
            a_reg <= alu_xor_result;
            f_reg <= alu_xor_flags;
          end
        end
        OPR1_D: begin
          lo_reg <= data_bus_ext;
          pc_reg <= pc_reg + 16'd1;
          if (op_reg == OP_LD_A) a_reg <= data_bus_ext;
        end
        OPR2_D: begin
          case (op_reg)
            OP_LD_SP: begin
              sp_reg <= {data_bus_ext, lo_reg};
              pc_reg <= pc_reg + 16'd1;
            end
            OP_LD_HL: begin
              {h_reg, l_reg} <= {data_bus_ext, lo_reg};
              pc_reg <= pc_reg + 16'd1;
            end
            default: pc_reg <= {data_bus_ext, lo_reg};
          endcase
        end
        EXEC: begin
          if (op_reg == OP_CB) begin
            if (lo_reg == CB_BIT7H) f_reg <= alu_bit_flags;
          end else if (jr_taken) begin
            pc_reg <= alu_pc_rel;
          end
        end
        WRITE: begin
          if (op_reg == OP_LDD) {h_reg, l_reg} <= {h_reg, l_reg} - 16'd1;
          else                  {h_reg, l_reg} <= {h_reg, l_reg} + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign dbg_pc = pc_reg;
  assign dbg_af = {a_reg, f_reg};
  assign dbg_hl = {h_reg, l_reg};
  assign dbg_sp = sp_reg;

endmodule

// File: tb/tb_sm83_cpu_core.sv
// Directed and random-program checks of sm83_cpu_core against an instruction-level model.
module tb_sm83_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  wire         mem_oe, mem_cs, mem_wr, halted;
  wire  [7:0]  data_bus;
  wire  [15:0] addr_bus, dbg_pc, dbg_af, dbg_hl, dbg_sp;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;

  logic [7:0]  rom [0:255];
  logic [7:0]  rom_q = 8'h00;
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];

  sm83_cpu_core #(.RESET_PC(16'h0000), .RESET_SP(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_oe       (mem_oe),
    .mem_cs       (mem_cs),
    .mem_wr       (mem_wr),
    .data_bus_ext (data_bus),
    .addr_bus_ext (addr_bus),
    .dbg_pc       (dbg_pc),
    .dbg_af       (dbg_af),
    .dbg_hl       (dbg_hl),
    .dbg_sp       (dbg_sp),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    if (a < 16'd256) return rom[a[7:0]];
    return 8'h76;
  endfunction

  // Synchronous ROM with one clock of read latency
  always @(posedge clk) if (mem_oe) rom_q <= rom_byte(addr_bus);
  assign data_bus = mem_oe ? rom_q : 8'hzz;

  always @(negedge clk) begin
    if (mem_wr) begin
      wr_addr_q.push_back(addr_bus);
      wr_data_q.push_back(data_bus);
    end
    if (mem_wr && mem_oe) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_supported(input logic [7:0] op);
    return op inside {8'h00, 8'h31, 8'h21, 8'h3E, 8'hAF, 8'h32, 8'h22,
                      8'hC3, 8'h18, 8'h20, 8'h28, 8'hCB, 8'h76};
  endfunction

  // Instruction-level interpreter; returns architectural state at HALT and clocks until halted rises
  task automatic model_run(output logic [15:0] pc_o, output logic [15:0] sp_o,
                           output logic [15:0] af_o, output logic [15:0] hl_o, output int cyc);
    logic [15:0] pc, sp, hl;
    logic [7:0]  a, op, b;
    bit          z, n, hf, c, done;
    pc = 0; sp = 0; hl = 0; a = 0; z = 0; n = 0; hf = 0; c = 0; done = 0; cyc = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int step = 0; step < 4000 && !done; step++) begin
      op = rom_byte(pc);
      pc = pc + 16'd1;
      case (op)
        8'h76: begin cyc += 3; done = 1; end
        8'h31: begin sp = {rom_byte(pc + 16'd1), rom_byte(pc)}; pc = pc + 16'd2; cyc += 7; end
        8'h21: begin hl = {rom_byte(pc + 16'd1), rom_byte(pc)}; pc = pc + 16'd2; cyc += 7; end
        8'hC3: begin pc = {rom_byte(pc + 16'd1), rom_byte(pc)}; cyc += 7; end
        8'h3E: begin a = rom_byte(pc); pc = pc + 16'd1; cyc += 5; end
        8'hAF: begin a = 0; z = 1; n = 0; hf = 0; c = 0; cyc += 3; end
        8'h32, 8'h22: begin
          exp_addr_q.push_back(hl);
          exp_data_q.push_back(a);
          hl = (op == 8'h32) ? hl - 16'd1 : hl + 16'd1;
          cyc += 4;
        end
        8'h18, 8'h20, 8'h28: begin
          b = rom_byte(pc);
          pc = pc + 16'd1;
          if (op == 8'h18 || (op == 8'h20 && !z) || (op == 8'h28 && z))
            pc = pc + 16'(int'($signed(b)));
          cyc += 6;
        end
        8'hCB: begin
          b = rom_byte(pc);
          pc = pc + 16'd1;
          if (b == 8'h7C) begin z = (hl < 16'h8000); n = 0; hf = 1; end
          cyc += 6;
        end
        default: cyc += 3;
      endcase
    end
    pc_o = pc; sp_o = sp; hl_o = hl;
    af_o = {a, z, n, hf, c, 4'b0000};
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    rst = 1'b1;
  endtask

  task automatic load_program(input logic [7:0] prog[$]);
    for (int i = 0; i < 256; i++) rom[i] = 8'h76;
    for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
  endtask

  task automatic compare_run(input string tag);
    logic [15:0] m_pc, m_sp, m_af, m_hl;
    int m_cyc, n, nw;
    bit reached;
    model_run(m_pc, m_sp, m_af, m_hl, m_cyc);
    reset_release();
    n = 0; reached = 0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      n++;
      if (halted) begin reached = 1; break; end
    end
    check({tag, "_halt_reached"}, 32'(reached), 32'd1);
    check({tag, "_cycles"}, n, m_cyc);
    check({tag, "_pc"}, dbg_pc, m_pc);
    check({tag, "_sp"}, dbg_sp, m_sp);
    check({tag, "_af"}, dbg_af, m_af);
    check({tag, "_hl"}, dbg_hl, m_hl);
    check({tag, "_wr_count"}, wr_addr_q.size(), exp_addr_q.size());
    nw = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < nw; i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], exp_addr_q[i]);
      check($sformatf("%s_wr%0d_data", tag, i), wr_data_q[i], exp_data_q[i]);
    end
    check({tag, "_oe_wr_overlap"}, overlap_cnt, 0);
    $display("prog %s cycles=%0d writes=%0d pc=%h af=%h hl=%h sp=%h",
             tag, n, wr_addr_q.size(), dbg_pc, dbg_af, dbg_hl, dbg_sp);
  endtask

  task automatic gen_random_program();
    int p, k, r;
    logic [7:0] op;
    for (int i = 0; i < 256; i++) rom[i] = 8'h76;
    p = 0;
    while (p < 230) begin
      r = $urandom_range(0, 11);
      case (r)
        0: begin rom[p] = 8'h00; p += 1; end
        1: begin rom[p] = 8'h31; rom[p+1] = 8'($urandom); rom[p+2] = 8'($urandom); p += 3; end
        2: begin rom[p] = 8'h21; rom[p+1] = 8'($urandom); rom[p+2] = 8'($urandom); p += 3; end
        3: begin rom[p] = 8'h3E; rom[p+1] = 8'($urandom); p += 2; end
        4: begin rom[p] = 8'hAF; p += 1; end
        5: begin rom[p] = 8'h32; p += 1; end
        6: begin rom[p] = 8'h22; p += 1; end
        7: begin
          k = $urandom_range(0, 3);
          rom[p] = 8'hC3; rom[p+1] = 8'(p + 3 + k); rom[p+2] = 8'h00;
          p += 3;
          for (int j = 0; j < k; j++) begin rom[p] = 8'h00; p += 1; end
        end
        8: begin
          k = $urandom_range(0, 3);
          r = $urandom_range(0, 2);
          rom[p] = (r == 0) ? 8'h18 : (r == 1) ? 8'h20 : 8'h28;
          rom[p+1] = 8'(k);
          p += 2;
          for (int j = 0; j < k; j++) begin rom[p] = 8'h00; p += 1; end
        end
        9:  begin rom[p] = 8'hCB; rom[p+1] = 8'h7C; p += 2; end
        10: begin rom[p] = 8'hCB; rom[p+1] = 8'($urandom); p += 2; end
        default: begin
          op = 8'($urandom);
          while (is_supported(op)) op = 8'($urandom);
          rom[p] = op;
          p += 1;
        end
      endcase
    end
  endtask

  initial begin
    bit seen;

    // Reset state and first bus cycle after release
    load_program('{8'h00});
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_oe", mem_oe, 0);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_addr", addr_bus, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", dbg_pc, 0);
    check("rst_sp", dbg_sp, 0);
    check("rst_af", dbg_af, 0);
    check("rst_hl", dbg_hl, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("first_addr", addr_bus, 16'h0000);
    check("first_oe", mem_oe, 1);
    check("first_cs", mem_cs, 1);
    check("first_wr", mem_wr, 0);
    repeat (2) @(posedge clk); #1;
    check("nop_pc_after3", dbg_pc, 16'h0001);
    $display("step nop pc=%h", dbg_pc);

    // LD SP,d16 timing
    load_program('{8'h31, 8'hFE, 8'hFF});
    reset_release();
    repeat (7) @(posedge clk); #1;
    check("ldsp_sp", dbg_sp, 16'hFFFE);
    check("ldsp_pc", dbg_pc, 16'h0003);
    $display("step ld_sp sp=%h pc=%h", dbg_sp, dbg_pc);

    // XOR A
    load_program('{8'hAF});
    reset_release();
    repeat (3) @(posedge clk); #1;
    check("xor_af", dbg_af, 16'h0080);
    $display("step xor af=%h", dbg_af);

    // LD (HL-),A write cycle
    load_program('{8'h3E, 8'h5A, 8'h21, 8'hFF, 8'h9F, 8'h32});
    reset_release();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mem_wr) begin seen = 1; break; end
    end
    check("ldd_wr_seen", 32'(seen), 1);
    check("ldd_addr", addr_bus, 16'h9FFF);
    check("ldd_oe", mem_oe, 0);
    check("ldd_cs", mem_cs, 1);
    check("ldd_data", data_bus, 8'h5A);
    @(posedge clk); #1;
    check("ldd_hl", dbg_hl, 16'h9FFE);
    check("ldd_wr_end", mem_wr, 0);
    $display("step ldd addr=9fff hl=%h", dbg_hl);

    // HL wrap in both directions
    load_program('{8'h3E, 8'h33, 8'h21, 8'h00, 8'h00, 8'h32, 8'h22, 8'h22});
    compare_run("hl_wrap");
    check("hl_wrap_final", dbg_hl, 16'h0001);

    // Boot clear loop over a shortened range (0x803F down to 0x8000)
    load_program('{8'h31, 8'hFE, 8'hFF, 8'hAF, 8'h21, 8'h3F, 8'h80, 8'h32,
                   8'hCB, 8'h7C, 8'h20, 8'hFB});
    compare_run("boot_loop");
    check("boot_halted", halted, 1);
    check("boot_pc", dbg_pc, 16'h000D);
    check("boot_hl", dbg_hl, 16'h7FFF);
    check("boot_nwrites", wr_addr_q.size(), 64);
    if (wr_addr_q.size() == 64) begin
      check("boot_first_addr", wr_addr_q[0], 16'h803F);
      check("boot_last_addr", wr_addr_q[63], 16'h8000);
    end

    // Reset asserted during a write aborts it
    load_program('{8'h3E, 8'hA5, 8'h21, 8'h34, 8'h12, 8'h32});
    reset_release();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mem_wr) begin seen = 1; break; end
    end
    check("abort_wr_seen", 32'(seen), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_mem_wr", mem_wr, 0);
    check("abort_mem_oe", mem_oe, 0);
    check("abort_pc", dbg_pc, 0);
    check("abort_af", dbg_af, 0);
    check("abort_hl", dbg_hl, 0);
    check("abort_sp", dbg_sp, 0);
    $display("step abort pc=%h hl=%h", dbg_pc, dbg_hl);

    // Random straight-line programs with forward jumps
    for (int t = 0; t < 20; t++) begin
      gen_random_program();
      compare_run($sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
